hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core; sits beside the forwarding unit in ID.
- Decides when PC and IF/ID hold, when a bubble enters ID/EX and when IF/ID is flushed.
- Covers the hazards forwarding cannot hide: load-use, branch operands resolved in ID, wrong-path fetch after a taken branch, and the multi-cycle mult/div unit.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- REG_W, 5, register address width
- MULT_CYCLES, 4, mult latency in cycles (>=2)
- DIV_CYCLES, 32, div latency in cycles (>=2)
- CNT_W, 6, mult/div down-counter width; must hold max(MULT_CYCLES,DIV_CYCLES)-1
- PERF_W, 32, stall counter width

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- IF_ID_RS  in  REG_W  rs of instruction in ID
- IF_ID_RT  in  REG_W  rt of instruction in ID
- ID_USES_RT  in  1  ID instruction reads rt as a source
- ID_BRANCH  in  1  ID holds beq/bne (compare done in ID)
- ID_MULDIV  in  1  ID holds mult/multu/div/divu
- ID_IS_DIV  in  1  qualifies ID_MULDIV: 1=div, 0=mult
- ID_MFHILO  in  1  ID holds mfhi/mflo
- ID_EX_RD  in  REG_W  destination register (already rt/rd muxed) of EX instruction
- ID_EX_REGWRITE  in  1  EX instruction writes a register
- ID_EX_MEMREAD  in  1  EX instruction is a load
- EX_MEM_RD  in  REG_W  destination of MEM instruction
- EX_MEM_MEMREAD  in  1  MEM instruction is a load
- BRANCH_TAKEN  in  1  taken branch/jump resolved this cycle
- PC_WRITE  out  1  PC update enable
- IF_ID_WRITE  out  1  IF/ID register enable
- ID_EX_BUBBLE  out  1  zero ID/EX control fields
- IF_ID_FLUSH  out  1  clear IF/ID to nop
- MULDIV_START  out  1  launch pulse to mult/div unit
- MULDIV_BUSY  out  1  mult/div in progress
- STALL_COUNT  out  PERF_W  stall cycles since reset

Behaviour:
- Register numbers equal to 0 never match anything.
- Source match: src_hit(r) = (r==IF_ID_RS) or (ID_USES_RT and r==IF_ID_RT).
- Combinational stall request, evaluated every cycle:
  - load_use: ID_EX_MEMREAD and src_hit(ID_EX_RD).
  - br_ex: ID_BRANCH and ID_EX_REGWRITE and src_hit(ID_EX_RD). This includes loads.
  - br_mem: ID_BRANCH and EX_MEM_MEMREAD and src_hit(EX_MEM_RD).
  - md_wait: (ID_MFHILO or ID_MULDIV) and busy, where busy = cnt!=0.
  - stall = any of the four.
- Stall outputs: PC_WRITE=IF_ID_WRITE=~stall; ID_EX_BUBBLE=stall.
- Flush: IF_ID_FLUSH=BRANCH_TAKEN.
  - Flush has priority over stall: when both are active, PC_WRITE=1, IF_ID_WRITE=1 and ID_EX_BUBBLE=stall.
  - A flushed ID instruction is suppressed: no MULDIV_START and no counter load.
- Load followed by a dependent branch is a 2-cycle stall with no dedicated state: br_ex holds it for cycle 1, then br_mem for cycle 2.
- Mult/div sequencer:
  - MULDIV_START = ID_MULDIV and ~stall and ~BRANCH_TAKEN; this is a 1-cycle pulse.
  - On the next clk edge cnt loads DIV_CYCLES-1 or MULT_CYCLES-1 per ID_IS_DIV. Otherwise, if cnt!=0, cnt decrements.
  - MULDIV_BUSY = cnt!=0. It is registered and deasserts exactly N cycles after the start pulse.
  - A second mult/div, or mfhi/mflo, in ID while busy stalls until the cycle where cnt==0.
- Perf counter: STALL_COUNT increments on every clk edge where stall=1 and BRANCH_TAKEN=0. It saturates at all-ones.
- Reset, asynchronous and valid mid-operation: cnt=0, STALL_COUNT=0.
  - The combinational outputs then follow inputs. With idle inputs: PC_WRITE=1, IF_ID_WRITE=1, ID_EX_BUBBLE=0, IF_ID_FLUSH=0, MULDIV_START=0, MULDIV_BUSY=0.
  - An in-flight mult/div is abandoned.
- Latency: all stall/flush outputs are same-cycle combinational. MULDIV_BUSY and STALL_COUNT are registered.

Decomposition:
- Shared package (cpu_defs): REG_W, register-zero constant, MULT_CYCLES/DIV_CYCLES defaults, opcode/funct constants the decoder uses to form ID_* flags.
- One sub-module, muldiv_sequencer: owns cnt, MULDIV_START qualification and MULDIV_BUSY.
- Hazard compare logic and the perf counter stay in the top.

Test Plan:
- lw $2 in EX (ID_EX_MEMREAD=1, ID_EX_RD=2), add $3,$2,$4 in ID -> exactly 1 cycle PC_WRITE=0, IF_ID_WRITE=0, ID_EX_BUBBLE=1; STALL_COUNT goes 0->1.
- lw $5 then beq $5,$0 in ID -> 2 stall cycles (br_ex then br_mem), then PC_WRITE=1; STALL_COUNT=2.
- Zero register and rt gating: lw $0 with src $0 -> no stall; lw $7 with IF_ID_RT=7, ID_USES_RT=0 -> no stall.
- div, MULT_CYCLES=4, DIV_CYCLES=32:
  - div in ID -> MULDIV_START pulse, MULDIV_BUSY high exactly 31 cycles.
  - mflo issued 2 cycles later -> stalls until BUSY falls, then proceeds.
- BRANCH_TAKEN=1 coincident with load_use stall and ID_MULDIV=1 -> IF_ID_FLUSH=1, PC_WRITE=1, ID_EX_BUBBLE=1, MULDIV_START=0, STALL_COUNT unchanged.
- Remaining cases:
  - rst_n low at cnt=10 -> MULDIV_BUSY=0 and STALL_COUNT=0 immediately.
  - With PERF_W=4 and 20 stall cycles -> STALL_COUNT holds 15.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared definitions for the 5-stage MIPS core.
// Holds the register-file geometry, the default mult/div latencies and the
// opcode/funct values the ID decoder uses to build the ID_* hazard flags.
// No ports (package).
package cpu_defs;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  localparam int MULT_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF  = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  // Decoder helpers that turn opcode/funct into the ID_* flags.
  function automatic logic is_muldiv(input logic [5:0] opcode, input logic [5:0] funct);
    return (opcode == OP_RTYPE) &&
           ((funct == FN_MULT) || (funct == FN_MULTU) ||
            (funct == FN_DIV)  || (funct == FN_DIVU));
  endfunction

  function automatic logic is_div(input logic [5:0] opcode, input logic [5:0] funct);
    return (opcode == OP_RTYPE) && ((funct == FN_DIV) || (funct == FN_DIVU));
  endfunction

  function automatic logic is_mfhilo(input logic [5:0] opcode, input logic [5:0] funct);
    return (opcode == OP_RTYPE) && ((funct == FN_MFHI) || (funct == FN_MFLO));
  endfunction

  function automatic logic is_branch(input logic [5:0] opcode);
    return (opcode == OP_BEQ) || (opcode == OP_BNE);
  endfunction

  function automatic logic is_load(input logic [5:0] opcode);
    return opcode == OP_LW;
  endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: tracks the multi-cycle mult/div unit.
// Ports:
//   clk, rst_n     - core clock, asynchronous active-low reset
//   id_muldiv      - mult/div sitting in ID
//   id_is_div      - 1 = div, 0 = mult (qualifies id_muldiv)
//   stall          - pipeline stall request from the hazard logic
//   branch_taken   - ID instruction is being flushed
//   muldiv_start   - one-cycle launch pulse to the unit
//   muldiv_busy    - unit still computing (cnt != 0)
module muldiv_sequencer
  import cpu_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic id_muldiv,
  input  logic id_is_div,
  input  logic stall,
  input  logic branch_taken,
  output logic muldiv_start,
  output logic muldiv_busy
);

  logic [CNT_W-1:0] cnt;

  // Launch only when the op actually leaves ID: not held by a stall and not
  // a wrong-path instruction being flushed. A second op while busy is held
  // by the md_wait stall, so a launch never lands on a running count.
  assign muldiv_start = id_muldiv & ~stall & ~branch_taken;

  // Remaining-cycle count: loaded with N-1 on launch so busy stays high for
  // exactly N-1 cycles after the start pulse, then counts down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (muldiv_start) begin
      cnt <= id_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign muldiv_busy = (cnt != '0);

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: pipeline sequencing for the 5-stage MIPS core.
// Holds PC and IF/ID, injects ID/EX bubbles and flushes IF/ID for the
// hazards forwarding cannot hide (load-use, ID-resolved branch operands,
// taken branches, mult/div latency) and counts stall cycles.
// Ports:
//   clk, rst_n                 - core clock, asynchronous active-low reset
//   IF_ID_RS/RT, ID_USES_RT    - source registers of the ID instruction
//   ID_BRANCH/MULDIV/IS_DIV/MFHILO - ID instruction class
//   ID_EX_RD/REGWRITE/MEMREAD  - EX instruction destination info
//   EX_MEM_RD/MEMREAD          - MEM instruction destination info
//   BRANCH_TAKEN               - taken branch/jump resolved this cycle
//   PC_WRITE, IF_ID_WRITE      - pipeline front-end enables
//   ID_EX_BUBBLE, IF_ID_FLUSH  - bubble / flush controls
//   MULDIV_START, MULDIV_BUSY  - mult/div launch pulse and busy status
//   STALL_COUNT                - saturating stall-cycle counter
module hazard_controller
  import cpu_defs::*;
#(
  parameter int REG_W       = REG_ADDR_W,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 6,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  IF_ID_RS,
  input  logic [REG_W-1:0]  IF_ID_RT,
  input  logic              ID_USES_RT,
  input  logic              ID_BRANCH,
  input  logic              ID_MULDIV,
  input  logic              ID_IS_DIV,
  input  logic              ID_MFHILO,
  input  logic [REG_W-1:0]  ID_EX_RD,
  input  logic              ID_EX_REGWRITE,
  input  logic              ID_EX_MEMREAD,
  input  logic [REG_W-1:0]  EX_MEM_RD,
  input  logic              EX_MEM_MEMREAD,
  input  logic              BRANCH_TAKEN,
  output logic              PC_WRITE,
  output logic              IF_ID_WRITE,
  output logic              ID_EX_BUBBLE,
  output logic              IF_ID_FLUSH,
  output logic              MULDIV_START,
  output logic              MULDIV_BUSY,
  output logic [PERF_W-1:0] STALL_COUNT
);

  logic ex_hit;
  logic mem_hit;
  logic load_use;
  logic br_ex;
  logic br_mem;
  logic md_wait;
  logic stall;

  // $0 is hardwired, so a write to it never creates a dependency.
  function automatic logic src_hit(input logic [REG_W-1:0] r,
                                   input logic [REG_W-1:0] rs,
                                   input logic [REG_W-1:0] rt,
                                   input logic             uses_rt);
    return (r != REG_W'(REG_ZERO)) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  assign ex_hit  = src_hit(ID_EX_RD,  IF_ID_RS, IF_ID_RT, ID_USES_RT);
  assign mem_hit = src_hit(EX_MEM_RD, IF_ID_RS, IF_ID_RT, ID_USES_RT);

  // Branches compare in ID, so they need even ALU results before forwarding
  // could deliver them; a load feeding a branch is covered by br_ex then
  // br_mem on consecutive cycles without any extra state.
  assign load_use = ID_EX_MEMREAD & ex_hit;
  assign br_ex    = ID_BRANCH & ID_EX_REGWRITE & ex_hit;
  assign br_mem   = ID_BRANCH & EX_MEM_MEMREAD & mem_hit;
  assign md_wait  = (ID_MFHILO | ID_MULDIV) & MULDIV_BUSY;
  assign stall    = load_use | br_ex | br_mem | md_wait;

  // A taken branch must still fetch the target, so it overrides the hold.
  assign PC_WRITE     = ~stall | BRANCH_TAKEN;
  assign IF_ID_WRITE  = ~stall | BRANCH_TAKEN;
  assign ID_EX_BUBBLE = stall;
  assign IF_ID_FLUSH  = BRANCH_TAKEN;

  muldiv_sequencer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_muldiv_sequencer (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_muldiv    (ID_MULDIV),
    .id_is_div    (ID_IS_DIV),
    .stall        (stall),
    .branch_taken (BRANCH_TAKEN),
    .muldiv_start (MULDIV_START),
    .muldiv_busy  (MULDIV_BUSY)
  );

  // Stall cycles overridden by a flush are not real stalls and are skipped;
  // the counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      STALL_COUNT <= '0;
    end else if (stall && !BRANCH_TAKEN && !(&STALL_COUNT)) begin
      STALL_COUNT <= STALL_COUNT + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed-vector bench for hazard_controller.
// Each vector drives one cycle of inputs and queues the hand-computed
// outputs for that cycle; a monitor pops and compares on the falling edge.
module tb_hazard_controller;

  localparam int REG_W  = 5;
  localparam int PERF_W = 4;

  typedef struct packed {
    logic             rst_n;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             uses_rt;
    logic             branch;
    logic             muldiv;
    logic             is_div;
    logic             mfhilo;
    logic [REG_W-1:0] ex_rd;
    logic             ex_regwrite;
    logic             ex_memread;
    logic [REG_W-1:0] mem_rd;
    logic             mem_memread;
    logic             taken;
  } stim_t;

  typedef struct packed {
    logic              pc_write;
    logic              if_id_write;
    logic              bubble;
    logic              flush;
    logic              start;
    logic              busy;
    logic [PERF_W-1:0] count;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [REG_W-1:0]  if_id_rs, if_id_rt, id_ex_rd, ex_mem_rd;
  logic              id_uses_rt, id_branch, id_muldiv, id_is_div, id_mfhilo;
  logic              id_ex_regwrite, id_ex_memread, ex_mem_memread, branch_taken;
  logic              pc_write, if_id_write, id_ex_bubble, if_id_flush;
  logic              muldiv_start, muldiv_busy;
  logic [PERF_W-1:0] stall_count;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  hazard_controller #(
    .REG_W       (REG_W),
    .MULT_CYCLES (4),
    .DIV_CYCLES  (32),
    .CNT_W       (6),
    .PERF_W      (PERF_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .IF_ID_RS       (if_id_rs),
    .IF_ID_RT       (if_id_rt),
    .ID_USES_RT     (id_uses_rt),
    .ID_BRANCH      (id_branch),
    .ID_MULDIV      (id_muldiv),
    .ID_IS_DIV      (id_is_div),
    .ID_MFHILO      (id_mfhilo),
    .ID_EX_RD       (id_ex_rd),
    .ID_EX_REGWRITE (id_ex_regwrite),
    .ID_EX_MEMREAD  (id_ex_memread),
    .EX_MEM_RD      (ex_mem_rd),
    .EX_MEM_MEMREAD (ex_mem_memread),
    .BRANCH_TAKEN   (branch_taken),
    .PC_WRITE       (pc_write),
    .IF_ID_WRITE    (if_id_write),
    .ID_EX_BUBBLE   (id_ex_bubble),
    .IF_ID_FLUSH    (if_id_flush),
    .MULDIV_START   (muldiv_start),
    .MULDIV_BUSY    (muldiv_busy),
    .STALL_COUNT    (stall_count)
  );

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  // Expected outputs: run = front end advances, bub = bubble, fl = flush.
  function automatic exp_t mk(input logic run, input logic bub, input logic fl,
                              input logic st, input logic busy, input int cnt);
    exp_t e;
    e.pc_write    = run;
    e.if_id_write = run;
    e.bubble      = bub;
    e.flush       = fl;
    e.start       = st;
    e.busy        = busy;
    e.count       = PERF_W'(cnt);
    return e;
  endfunction

  task automatic drive(input stim_t s);
    rst_n          = s.rst_n;
    if_id_rs       = s.rs;
    if_id_rt       = s.rt;
    id_uses_rt     = s.uses_rt;
    id_branch      = s.branch;
    id_muldiv      = s.muldiv;
    id_is_div      = s.is_div;
    id_mfhilo      = s.mfhilo;
    id_ex_rd       = s.ex_rd;
    id_ex_regwrite = s.ex_regwrite;
    id_ex_memread  = s.ex_memread;
    ex_mem_rd      = s.mem_rd;
    ex_mem_memread = s.mem_memread;
    branch_taken   = s.taken;
  endtask

  task automatic applyStimulus(input string name, input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    drive(s);
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    exp_t act;
    act = '{pc_write, if_id_write, id_ex_bubble, if_id_flush,
            muldiv_start, muldiv_busy, stall_count};
    checks++;
    if (act !== e) begin
      errors++;
      $display("[TB] FAIL %s: got pc=%b ifid=%b bub=%b fl=%b st=%b busy=%b cnt=%0d, expected pc=%b ifid=%b bub=%b fl=%b st=%b busy=%b cnt=%0d",
               name, act.pc_write, act.if_id_write, act.bubble, act.flush,
               act.start, act.busy, act.count, e.pc_write, e.if_id_write,
               e.bubble, e.flush, e.start, e.busy, e.count);
    end
  endtask

  // Monitor: the DUT presents a fresh output set every cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      checkOutput(name_q.pop_front(), exp_q.pop_front());
    end
  end

  task automatic doReset();
    stim_t s;
    s = idle();
    s.rst_n = 1'b0;
    applyStimulus("reset", s, mk(1, 0, 0, 0, 0, 0));
  endtask

  initial begin
    stim_t s;
    drive(idle());
    rst_n = 1'b0;

    doReset();

    // Load-use: lw $2 in EX, add $3,$2,$4 in ID.
    s = idle(); s.ex_memread = 1; s.ex_regwrite = 1; s.ex_rd = 2;
    s.rs = 2; s.rt = 4; s.uses_rt = 1;
    applyStimulus("load_use", s, mk(0, 1, 0, 0, 0, 0));
    applyStimulus("load_use_release", idle(), mk(1, 0, 0, 0, 0, 1));

    // lw $5 then beq $5,$0: br_ex then br_mem.
    doReset();
    s = idle(); s.ex_memread = 1; s.ex_regwrite = 1; s.ex_rd = 5;
    s.branch = 1; s.rs = 5; s.rt = 0; s.uses_rt = 1;
    applyStimulus("ld_br_ex", s, mk(0, 1, 0, 0, 0, 0));
    s = idle(); s.mem_memread = 1; s.mem_rd = 5;
    s.branch = 1; s.rs = 5; s.rt = 0; s.uses_rt = 1;
    applyStimulus("ld_br_mem", s, mk(0, 1, 0, 0, 0, 1));
    s = idle(); s.branch = 1; s.rs = 5; s.uses_rt = 1;
    applyStimulus("ld_br_go", s, mk(1, 0, 0, 0, 0, 2));

    // Zero register and rt gating.
    s = idle(); s.ex_memread = 1; s.ex_regwrite = 1; s.ex_rd = 0;
    s.rs = 0; s.rt = 0; s.uses_rt = 1;
    applyStimulus("zero_reg", s, mk(1, 0, 0, 0, 0, 2));
    s = idle(); s.ex_memread = 1; s.ex_regwrite = 1; s.ex_rd = 7;
    s.rs = 3; s.rt = 7; s.uses_rt = 0;
    applyStimulus("rt_unused", s, mk(1, 0, 0, 0, 0, 2));
    s.uses_rt = 1;
    applyStimulus("rt_used", s, mk(0, 1, 0, 0, 0, 2));
    s = idle(); s.ex_regwrite = 1; s.ex_rd = 9; s.rs = 9;
    applyStimulus("alu_fwd", s, mk(1, 0, 0, 0, 0, 3));
    s.branch = 1;
    applyStimulus("alu_branch", s, mk(0, 1, 0, 0, 0, 3));
    applyStimulus("idle_a", idle(), mk(1, 0, 0, 0, 0, 4));

    // Flush coincident with load-use stall and a mult/div in ID.
    s = idle(); s.taken = 1; s.ex_memread = 1; s.ex_regwrite = 1; s.ex_rd = 2;
    s.rs = 2; s.muldiv = 1;
    applyStimulus("flush_prio", s, mk(1, 1, 1, 0, 0, 4));
    applyStimulus("flush_after", idle(), mk(1, 0, 0, 0, 0, 4));

    // div then mflo two cycles later; busy for exactly 31 cycles.
    doReset();
    s = idle(); s.muldiv = 1; s.is_div = 1;
    applyStimulus("div_start", s, mk(1, 0, 0, 1, 0, 0));
    applyStimulus("div_busy1", idle(), mk(1, 0, 0, 0, 1, 0));
    s = idle(); s.mfhilo = 1;
    for (int i = 2; i <= 31; i++) begin
      applyStimulus($sformatf("mflo_wait%0d", i), s,
                    mk(0, 1, 0, 0, 1, (i - 2 > 15) ? 15 : i - 2));
    end
    applyStimulus("mflo_go", s, mk(1, 0, 0, 0, 0, 15));
    applyStimulus("div_done", idle(), mk(1, 0, 0, 0, 0, 15));

    // mult busy blocks a following div, then reset mid-divide at cnt=10.
    doReset();
    s = idle(); s.muldiv = 1; s.is_div = 0;
    applyStimulus("mult_start", s, mk(1, 0, 0, 1, 0, 0));
    s = idle(); s.muldiv = 1; s.is_div = 1;
    applyStimulus("div_wait1", s, mk(0, 1, 0, 0, 1, 0));
    applyStimulus("div_wait2", s, mk(0, 1, 0, 0, 1, 1));
    applyStimulus("div_wait3", s, mk(0, 1, 0, 0, 1, 2));
    applyStimulus("div_launch", s, mk(1, 0, 0, 1, 0, 3));
    for (int k = 0; k < 21; k++) begin
      applyStimulus($sformatf("div_run%0d", k), idle(), mk(1, 0, 0, 0, 1, 3));
    end
    doReset();
    applyStimulus("post_reset", idle(), mk(1, 0, 0, 0, 0, 0));

    // 20 load-use stalls into a 4-bit counter saturate at 15.
    s = idle(); s.ex_memread = 1; s.ex_regwrite = 1; s.ex_rd = 6; s.rs = 6;
    for (int j = 0; j < 20; j++) begin
      applyStimulus($sformatf("sat%0d", j), s, mk(0, 1, 0, 0, 0, (j > 15) ? 15 : j));
    end
    applyStimulus("sat_hold", idle(), mk(1, 0, 0, 0, 0, 15));

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
